uart_rx_param: RTL
==================

# uart_rx_param

Parametrised UART receiver, the successor to the fixed 8N1 `uart_rx`. It adds configurable frame format (data bits, parity, stop bits), 16x-oversampled majority-vote sampling, break detection, and a valid/ready output with overrun reporting. It sits between the asynchronous `rx_serial` pin and the system-side consumer, in the same clock domain as `uart_tx`.

## Interface
- `CLK_FREQ`, 50_000_000, system clock in Hz
- `BAUD_RATE`, 115200, line rate in bit/s
- `OVERSAMPLE`, 16, sample ticks per bit; legal values are 8 or 16
- `DATA_BITS`, 8, data bits per frame, 5 to 9
- `PARITY_MODE`, 0, 0 = none, 1 = even, 2 = odd
- `STOP_BITS`, 1, 1 or 2
- `FIFO_DEPTH`, 8, output FIFO entries, power of 2 and at least 2; used only with the macro
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `rx_serial`  in  1  asynchronous serial line, idles high
- `rx_data`  out  DATA_BITS  received word, LSB is the first bit on the line
- `rx_valid`  out  1  `rx_data`/`rx_status` hold a word
- `rx_ready`  in  1  consumer accepts the word when `rx_valid && rx_ready`
- `rx_status`  out  4  {break, overrun, parity_err, framing_err} for the presented word
- `rx_error`  out  1  OR of `rx_status` while `rx_valid`, else 0

## Operation
- **Synchroniser:** 2-FF synchroniser on `rx_serial`, reset value 1. The FSM sees only the synchronised `rxs`.
- **Tick generator:** the divider is `round(CLK_FREQ/(BAUD_RATE*OVERSAMPLE))`, and the counter is `$clog2(divider)` bits wide. It produces a 1-clk `tick` and restarts at 0 on every falling edge of `rxs` detected in IDLE.
- **Bit sampling:** within each bit, ticks are numbered 0..OVERSAMPLE-1. The bit value is the majority of `rxs` at ticks OS/2-1, OS/2 and OS/2+1, and the FSM advances at tick OS-1.
- **States:** RESYNC, IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - RESYNC is entered on reset. It requires `rxs`=1 for OVERSAMPLE consecutive ticks, then goes to IDLE.
  - IDLE goes to START on `rxs` 1→0.
  - START: if the majority value is 1, it is a false start; return to IDLE with no output. Otherwise go to DATA.
  - DATA shifts DATA_BITS samples LSB-first, then goes to PARITY if PARITY_MODE≠0, else to STOP.
  - PARITY: `parity_err` = sample ≠ (even: XOR of data; odd: ~XOR of data).
  - STOP samples STOP_BITS bits. Any stop sample of 0 sets `framing_err`.
- **Break:** break is set when all data bits, the parity bit (if present) and the first stop bit are 0. When break is set, `framing_err` is also set.
- **End of frame:**
  - On the last stop sample decision, the word is pushed and the FSM goes to IDLE.
  - If `framing_err` is set, the FSM goes to WAIT_IDLE instead, which waits for `rxs`=1 and then goes to IDLE.
- **Overrun:**
  - If storage is full at push time, the new word is dropped and a sticky `ovr` flag is set.
  - `ovr` is written into the overrun bit of the next successfully pushed word, then cleared.
- **Push and pop in one clock:**
  - A push in the same clock as a pop is always accepted, including when storage is full.
  - A push into empty storage with `rx_ready`=1 is not bypassed; the word appears on the next clock.

## Timing
- **Reset values:** `rx_data`=0, `rx_valid`=0, `rx_status`=0, `rx_error`=0, FSM in RESYNC, `ovr`=0, storage empty.
- **Input latency:** the line reaches the FSM 2 clk after `rx_serial` changes.
- **Output latency:** `rx_valid` rises 1 clk after the final stop-bit decision tick, which is about 0.5 bit before the end of the nominal last stop bit.
- **Handshake:** `rx_valid`, `rx_data` and `rx_status` are registered. Once `rx_valid` is high they stay stable until a handshake occurs.
- **Reset mid-frame:** the partial word is discarded with no output. Reception resumes only after the RESYNC idle time.
- **Back-to-back frames:** a start edge is accepted on the first clk in IDLE. There is no inter-frame gap requirement.

## Configuration
- **`UART_RX_PARAM_FIFO_EN` defined:** words are buffered in a FIFO_DEPTH-entry FIFO. "Full" means FIFO_DEPTH words are stored. `rx_valid` = FIFO not empty, and the head word is presented.
- **Macro undefined:** a single holding register is used and FIFO_DEPTH is ignored. "Full" means `rx_valid`=1.

## Structure
- **Package `uart_pkg`:**
  - `parity_mode_e` (PAR_NONE, PAR_EVEN, PAR_ODD).
  - `rx_state_e`.
  - `rx_status_t` packed struct {brk, ovr, par, frm}.
  - Function `calc_divisor(clk, baud, os)`.
- **Sub-module `uart_baud_tick`:** the divider/counter with `restart` input and `tick` output. It is shared with `uart_tx`.
- **Inline logic:** the FIFO is written inline in this module, not as a separate sub-module.

## Test plan
All scenarios use 50 MHz, 115200 baud, OVERSAMPLE 16 (divider 27), 8N1 defaults unless stated.

- **Basic frame:** send 0xA5 with `rx_ready`=1. Expect one `rx_valid` pulse, `rx_data`=0xA5, `rx_status`=0.
- **7E2 and 7O2 parity:** with DATA_BITS=7, PARITY_MODE=1, STOP_BITS=2:
  - send 0x35 with correct parity bit 0. Expect `rx_data`=0x35, `rx_status`=0.
  - send 0x35 with parity bit forced to 1. Expect `parity_err`=1.
  - with PARITY_MODE=2, send 0x35 with parity bit 1. Expect `rx_status`=0.
- **Glitches:**
  - a 0.25-bit low glitch on the idle line gives no output, and the FSM returns to IDLE.
  - a 1-tick glitch at the mid-bit of data bit 3 of 0x00 still yields `rx_data`=0x00.
- **Framing and break:**
  - send 0x55 with stop bit 0. Expect `framing_err`=1, `break`=0.
  - hold the line low for 2 frame times. Expect one word 0x00 with `break`=1 and `framing_err`=1, and no further word until the line returns high.
- **Overrun:** with `rx_ready`=0, send 0x11, 0x22, 0x33.
  - Macro undefined: after raising `rx_ready`, read 0x11 (ovr=0). Send 0x44 and expect 0x44 with ovr=1.
  - Macro defined, FIFO_DEPTH=2: read 0x11, then 0x22. Then 0x44 arrives with ovr=1.
- **Reset mid-frame:** assert `rst` during data bit 4 of 0xF0, then release with the line high. Expect no output. A following 0x3C frame, sent after more than 1 idle bit, is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and helpers: parity modes, receiver states, status flags
// and the baud-divisor calculation used by uart_baud_tick.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_mode_e;

    typedef enum logic [2:0] {
        RX_RESYNC    = 3'd0,
        RX_IDLE      = 3'd1,
        RX_START     = 3'd2,
        RX_DATA      = 3'd3,
        RX_PARITY    = 3'd4,
        RX_STOP      = 3'd5,
        RX_WAIT_IDLE = 3'd6
    } rx_state_e;

    typedef struct packed {
        logic brk;
        logic ovr;
        logic par;
        logic frm;
    } rx_status_t;

    // Rounded clk/(baud*os), never below 1 so the tick counter stays legal.
    function automatic int calc_divisor(input int clk, input int baud, input int os);
        longint den;
        longint quo;
        den = longint'(baud) * longint'(os);
        quo = (longint'(clk) + den / 2) / den;
        if (quo < 64'sd1) quo = 64'sd1;
        return int'(quo);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator shared by uart_rx_param and uart_tx: one-clock
// tick every DIVISOR clocks, re-phased to zero by restart.
module uart_baud_tick #(
    parameter int DIVISOR = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || (cnt_q == LAST)) cnt_d = '0;
    end

    assign tick = (cnt_q == LAST) && !restart;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with valid/ready output and overrun flag.
// Define UART_RX_PARAM_FIFO_EN to buffer words in a FIFO_DEPTH FIFO instead of one register.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [3:0]           rx_status,
    output logic                 rx_error
);

    localparam int DIVISOR = calc_divisor(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int OSW     = $clog2(OVERSAMPLE);
    localparam int BCW     = $clog2(DATA_BITS);

    localparam logic [OSW-1:0] T_S0  = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [OSW-1:0] T_S1  = OSW'(OVERSAMPLE / 2);
    localparam logic [OSW-1:0] T_S2  = OSW'(OVERSAMPLE / 2 + 1);
    localparam logic [OSW-1:0] T_END = OSW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

    localparam parity_mode_e PMODE = parity_mode_e'(PARITY_MODE[1:0]);
    localparam logic HAS_PARITY = (PMODE != PAR_NONE);
    localparam logic ODD_PAR    = (PMODE == PAR_ODD);
    localparam logic ONE_STOP   = (STOP_BITS == 1);

    if (!((OVERSAMPLE == 8) || (OVERSAMPLE == 16)) || (DATA_BITS < 5) || (DATA_BITS > 9) ||
        (PARITY_MODE < 0) || (PARITY_MODE > 2) || !((STOP_BITS == 1) || (STOP_BITS == 2)) ||
        (FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_param_check
        $error("uart_rx_param: illegal parameter combination");
    end

    logic [1:0] sync_q;
    logic       rxs;
    logic       rxs_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= 2'b11;
            rxs_prev_q <= 1'b1;
        end else begin
            sync_q     <= {sync_q[0], rx_serial};
            rxs_prev_q <= rxs;
        end
    end

    assign rxs = sync_q[1];

    logic restart;
    logic tick;

    uart_baud_tick #(
        .DIVISOR (DIVISOR)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    rx_state_e            state_q,   state_d;
    logic [OSW-1:0]       os_cnt_q,  os_cnt_d;
    logic [1:0]           samp_q,    samp_d;
    logic                 bit_q,     bit_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic                 zero_q,    zero_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_q,     frm_d;
    logic                 brk_q,     brk_d;

    logic       vote;
    logic       stop_last;
    logic       push;
    logic       push_brk;
    logic       push_frm;
    logic       ovr_q, ovr_d;
    rx_status_t push_stat;

    assign vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);
    assign stop_last = ONE_STOP | stop_cnt_q;

    // Samples land at mid-bit; most bits advance at the last tick, but the
    // start bit may abort and the final stop bit finishes at its mid-point.
    always_comb begin
        state_d    = state_q;
        os_cnt_d   = os_cnt_q;
        samp_d     = samp_q;
        bit_d      = bit_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        zero_d     = zero_q;
        par_err_d  = par_err_q;
        frm_d      = frm_q;
        brk_d      = brk_q;
        restart    = 1'b0;
        push       = 1'b0;
        push_brk   = brk_q;
        push_frm   = frm_q;

        unique case (state_q)
            RX_RESYNC: begin
                if (!rxs) begin
                    os_cnt_d = '0;
                end else if (tick) begin
                    os_cnt_d = os_cnt_q + 1'b1;
                    if (os_cnt_q == T_END) state_d = RX_IDLE;
                end
            end
            RX_IDLE: begin
                if (rxs_prev_q && !rxs) begin
                    restart    = 1'b1;
                    os_cnt_d   = '0;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    zero_d     = 1'b1;
                    par_err_d  = 1'b0;
                    frm_d      = 1'b0;
                    brk_d      = 1'b0;
                    state_d    = RX_START;
                end
            end
            RX_WAIT_IDLE: begin
                if (rxs) state_d = RX_IDLE;
            end
            default: begin
                if (tick) begin
                    os_cnt_d = os_cnt_q + 1'b1;
                    if (os_cnt_q == T_S0) samp_d[0] = rxs;
                    if (os_cnt_q == T_S1) samp_d[1] = rxs;
                    if (os_cnt_q == T_S2) bit_d = vote;
                    case (state_q)
                        RX_START: begin
                            if ((os_cnt_q == T_S2) && vote) state_d = RX_IDLE;
                            else if (os_cnt_q == T_END)     state_d = RX_DATA;
                        end
                        RX_DATA: begin
                            if (os_cnt_q == T_END) begin
                                shift_d = {bit_q, shift_q[DATA_BITS-1:1]};
                                zero_d  = zero_q & ~bit_q;
                                if (bit_cnt_q == LAST_BIT)
                                    state_d = HAS_PARITY ? RX_PARITY : RX_STOP;
                                else
                                    bit_cnt_d = bit_cnt_q + 1'b1;
                            end
                        end
                        RX_PARITY: begin
                            if (os_cnt_q == T_END) begin
                                par_err_d = bit_q ^ (^shift_q) ^ ODD_PAR;
                                zero_d    = zero_q & ~bit_q;
                                state_d   = RX_STOP;
                            end
                        end
                        RX_STOP: begin
                            if (stop_last) begin
                                if (os_cnt_q == T_S2) begin
                                    push     = 1'b1;
                                    push_brk = stop_cnt_q ? brk_q : (zero_q & ~vote);
                                    push_frm = frm_q | ~vote | push_brk;
                                    state_d  = push_frm ? RX_WAIT_IDLE : RX_IDLE;
                                end
                            end else if (os_cnt_q == T_END) begin
                                brk_d      = zero_q & ~bit_q;
                                frm_d      = frm_q | ~bit_q;
                                stop_cnt_d = 1'b1;
                            end
                        end
                        default: state_d = RX_RESYNC;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RX_RESYNC;
            os_cnt_q   <= '0;
            samp_q     <= 2'b11;
            bit_q      <= 1'b1;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            zero_q     <= 1'b0;
            par_err_q  <= 1'b0;
            frm_q      <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            os_cnt_q   <= os_cnt_d;
            samp_q     <= samp_d;
            bit_q      <= bit_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            zero_q     <= zero_d;
            par_err_q  <= par_err_d;
            frm_q      <= frm_d;
            brk_q      <= brk_d;
        end
    end

    assign push_stat = '{brk: push_brk, ovr: ovr_q, par: par_err_q, frm: push_frm};

    logic full;
    logic pop;
    logic accept;

    assign pop    = rx_valid & rx_ready;
    assign accept = push & (~full | pop);

`ifdef UART_RX_PARAM_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem_data_q [FIFO_DEPTH];
    rx_status_t           mem_stat_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q,  count_d;

    assign full      = (count_q == (AW+1)'(FIFO_DEPTH));
    assign rx_valid  = (count_q != '0);
    assign rx_data   = mem_data_q[rd_ptr_q];
    assign rx_status = mem_stat_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (accept && !pop)      count_d = count_q + 1'b1;
        else if (!accept && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_stat_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (accept) begin
                mem_data_q[wr_ptr_q] <= shift_q;
                mem_stat_q[wr_ptr_q] <= push_stat;
            end
        end
    end
`else
    logic [DATA_BITS-1:0] hold_data_q,  hold_data_d;
    rx_status_t           hold_stat_q,  hold_stat_d;
    logic                 hold_valid_q, hold_valid_d;

    assign full      = hold_valid_q;
    assign rx_valid  = hold_valid_q;
    assign rx_data   = hold_data_q;
    assign rx_status = hold_stat_q;

    always_comb begin
        hold_data_d  = hold_data_q;
        hold_stat_d  = hold_stat_q;
        hold_valid_d = hold_valid_q;
        if (accept) begin
            hold_data_d  = shift_q;
            hold_stat_d  = push_stat;
            hold_valid_d = 1'b1;
        end else if (pop) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data_q  <= '0;
            hold_stat_q  <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            hold_data_q  <= hold_data_d;
            hold_stat_q  <= hold_stat_d;
            hold_valid_q <= hold_valid_d;
        end
    end
`endif

    // A dropped word leaves ovr set until some later word carries it out.
    always_comb begin
        ovr_d = ovr_q;
        if (push) ovr_d = ~accept;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovr_q <= 1'b0;
        else     ovr_q <= ovr_d;
    end

    assign rx_error = rx_valid & (|rx_status);

endmodule
